// File: rtl/regfile_bypass_if.sv
// rtl/regfile_bypass_if.sv - write/read bus bundle for the bypassing register file
interface regfile_bypass_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     busy;
  logic                     wr_drop;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data, busy, wr_drop
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr,
    output rd_data, busy, wr_drop
  );
endinterface

// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - multi-read-port register file with self-clear after reset and write bypass
module regfile_bypass #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic             clock,
  input  logic             reset,
  regfile_bypass_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic               wr_drop_q, wr_drop_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic               busy;
  logic               wr_commit;
  logic [NUM_RD*DATA_W-1:0] rd_flat;

  assign busy      = (state_q == CLEAR);
  // Writes to a hardwired zero entry are accepted silently but never land or forward
  assign wr_commit = bus.wr_en && !busy && !((ZERO_REG != 0) && (bus.wr_addr == '0));

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_drop_d = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        wr_drop_d = bus.wr_en;
        if (clr_cnt_q == '1) state_d = READY;
      end
      READY: begin
        clr_cnt_d = '0;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Storage is left untouched on reset edges; the clear walk zeroes it afterwards
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (busy) begin
        mem_q[clr_cnt_q] <= '0;
      end else if (wr_commit) begin
        mem_q[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    ra      = '0;
    rd_flat = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = bus.rd_addr[i*ADDR_W +: ADDR_W];
      if (busy) begin
        rd_flat[i*DATA_W +: DATA_W] = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_flat[i*DATA_W +: DATA_W] = '0;
      end else if ((BYPASS != 0) && wr_commit && (bus.wr_addr == ra)) begin
        rd_flat[i*DATA_W +: DATA_W] = bus.wr_data;
      end else begin
        rd_flat[i*DATA_W +: DATA_W] = mem_q[ra];
      end
    end
  end

  assign bus.rd_data = rd_flat;
  assign bus.busy    = busy;
  assign bus.wr_drop = wr_drop_q;
endmodule

// File: tb/tb_regfile_bypass.sv
// tb/tb_regfile_bypass.sv - scoreboard bench for two register file variants sharing one stimulus
module tb_regfile_bypass;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic           reset;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic [AW-1:0]  ra0, ra1;

  regfile_bypass_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_b ();
  regfile_bypass_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_n ();

  assign bus_b.wr_en   = wr_en;
  assign bus_b.wr_addr = wr_addr;
  assign bus_b.wr_data = wr_data;
  assign bus_b.rd_addr = {ra1, ra0};
  assign bus_n.wr_en   = wr_en;
  assign bus_n.wr_addr = wr_addr;
  assign bus_n.wr_data = wr_data;
  assign bus_n.rd_addr = {ra1, ra0};

  regfile_bypass #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1), .ZERO_REG(1)) u_dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  regfile_bypass #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0), .ZERO_REG(0)) u_dut_n (
    .clock (clock),
    .reset (reset),
    .bus   (bus_n.slave)
  );

  // Reference: contents per variant plus the number of clear edges still owed
  logic [DW-1:0] mem_b [DEPTH];
  logic [DW-1:0] mem_n [DEPTH];
  int            clear_left = DEPTH;
  logic          drop_m = 1'b0;

  typedef struct {
    logic          busy;
    logic          drop;
    logic [DW-1:0] b0, b1, n0, n1;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  function automatic void model_edge();
    if (reset) begin
      clear_left = DEPTH;
      drop_m     = 1'b0;
    end else if (clear_left > 0) begin
      mem_b[DEPTH - clear_left] = '0;
      mem_n[DEPTH - clear_left] = '0;
      clear_left = clear_left - 1;
      drop_m     = wr_en;
    end else begin
      drop_m = 1'b0;
      if (wr_en) begin
        if (wr_addr != 0) mem_b[wr_addr] = wr_data;
        mem_n[wr_addr] = wr_data;
      end
    end
  endfunction

  function automatic logic [DW-1:0] expect_rd(bit byp, bit zr, logic [AW-1:0] a);
    if (clear_left > 0) return '0;
    if (zr && a == 0) return '0;
    if (byp && wr_en && !(zr && wr_addr == 0) && wr_addr == a) return wr_data;
    return zr ? mem_b[a] : mem_n[a];
  endfunction

  task automatic cycle(input bit rst, input bit we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    exp_t e;
    @(posedge clock);
    #1;
    model_edge();
    cyc     = cyc + 1;
    reset   = rst;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    ra0     = a0;
    ra1     = a1;
    e.busy  = (clear_left > 0);
    e.drop  = drop_m;
    e.b0    = expect_rd(1'b1, 1'b1, a0);
    e.b1    = expect_rd(1'b1, 1'b1, a1);
    e.n0    = expect_rd(1'b0, 1'b0, a0);
    e.n1    = expect_rd(1'b0, 1'b0, a1);
    e.cyc   = cyc;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      cycle(1'b0, 1'b0, '0, '0, AW'($urandom), AW'($urandom));
  endtask

  task automatic chk(input string name, input int c, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("busy_b",  e.cyc, DW'(bus_b.busy),    DW'(e.busy));
        chk("busy_n",  e.cyc, DW'(bus_n.busy),    DW'(e.busy));
        chk("drop_b",  e.cyc, DW'(bus_b.wr_drop), DW'(e.drop));
        chk("drop_n",  e.cyc, DW'(bus_n.wr_drop), DW'(e.drop));
        chk("rd0_b",   e.cyc, bus_b.rd_data[0*DW +: DW], e.b0);
        chk("rd1_b",   e.cyc, bus_b.rd_data[1*DW +: DW], e.b1);
        chk("rd0_n",   e.cyc, bus_n.rd_data[0*DW +: DW], e.n0);
        chk("rd1_n",   e.cyc, bus_n.rd_data[1*DW +: DW], e.n1);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] wa;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    ra0     = '0;
    ra1     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_b[i] = 'x;
      mem_n[i] = 'x;
    end

    // Reset edge, then the clear walk with a rejected write partway through
    cycle(1'b0, 1'b0, '0, '0, '0, '0);
    for (int k = 0; k < DEPTH; k++) begin
      if (k == 9) cycle(1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3);
      else        cycle(1'b0, 1'b0, '0, '0, AW'($urandom), AW'($urandom));
    end

    for (int i = 0; i < DEPTH / 2; i++)
      cycle(1'b0, 1'b0, '0, '0, AW'(i), AW'(i + DEPTH / 2));

    cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    cycle(1'b0, 1'b0, '0, '0, 5'd5, 5'd5);

    cycle(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
    cycle(1'b0, 1'b0, '0, '0, 5'd0, 5'd0);
    cycle(1'b0, 1'b0, '0, '0, 5'd0, 5'd0);

    for (int k = 0; k < 400; k++) begin
      wa = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, wa, $urandom,
            ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 7)),
            ($urandom_range(0, 2) == 0) ? wa : AW'($urandom));
    end
    for (int k = 0; k < 40 && clear_left > 0; k++) idle(1);

    // Reset in the middle of a clear restarts the walk
    cycle(1'b1, 1'b0, '0, '0, '0, '0);
    idle(20);
    cycle(1'b1, 1'b1, 5'd7, 32'h77, 5'd7, 5'd7);
    idle(DEPTH + 1);

    cycle(1'b0, 1'b1, 5'd31, 32'h11, 5'd31, 5'd31);
    cycle(1'b0, 1'b0, '0, '0, 5'd31, 5'd30);
    cycle(1'b1, 1'b0, '0, '0, 5'd31, 5'd31);
    idle(DEPTH + 1);
    cycle(1'b0, 1'b0, '0, '0, 5'd31, 5'd31);
    idle(2);

    repeat (3) @(negedge clock);
    #1;
    n_cmp = n_cmp + 1;
    if (sb.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
